sa_ctrl: RTL and testbench



---
 rtl/sa_ctrl.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_sa_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_ctrl.sv
// sa_ctrl - tile controller that acts as the initiator of the 4x4 systolic_array.
//
// A job runs in these phases:
//   LOAD  : read four A words and four B words from the global buffers
//   ARM   : give the array one cycle to latch its operands while still held
//   RUN   : let the array compute until it pulses sa_done
//   DRAIN : write the four C rows back to the global C buffer
//   FIN   : pulse done
//
// Optional build macro: SA_CTRL_TIMEOUT_EN
//   Adds a RUN-phase watchdog. If sa_done does not arrive within
//   TIMEOUT_CYCLES RUN cycles, the job ends with err=1 and no C writes.
//   Without the macro, RUN waits indefinitely and err is tied low.
//
// Ports:
//   clk, rst_n                   clock; asynchronous active-low reset
//   start                        job request, accepted only in IDLE
//   a_base, b_base, c_base       buffer base indices, latched on start
//   busy, done, err              job status; err is valid with done
//   a_index, b_index             A/B read index (RAM has 1-cycle read latency)
//   a_data_in, b_data_in         A/B read data
//   c_index, c_wr_en, c_data_out C buffer write port
//   sa_rst_n                     array reset / run enable, high only in RUN
//   local_buffer_A0..A3, B0..B3  operands presented to the array
//   sa_done                      array completion pulse
//   local_buffer_C0..C3          array result rows
module sa_ctrl #(
    parameter int ADDR_BITS      = 16,
    parameter int DATA_BITS      = 32,
    parameter int DATAC_BITS     = 128,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_BITS-1:0]  a_base,
    input  logic [ADDR_BITS-1:0]  b_base,
    input  logic [ADDR_BITS-1:0]  c_base,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_BITS-1:0]  a_index,
    output logic [ADDR_BITS-1:0]  b_index,
    input  logic [DATA_BITS-1:0]  a_data_in,
    input  logic [DATA_BITS-1:0]  b_data_in,
    output logic [ADDR_BITS-1:0]  c_index,
    output logic                  c_wr_en,
    output logic [DATAC_BITS-1:0] c_data_out,
    output logic                  sa_rst_n,
    output logic [DATA_BITS-1:0]  local_buffer_A0,
    output logic [DATA_BITS-1:0]  local_buffer_A1,
    output logic [DATA_BITS-1:0]  local_buffer_A2,
    output logic [DATA_BITS-1:0]  local_buffer_A3,
    output logic [DATA_BITS-1:0]  local_buffer_B0,
    output logic [DATA_BITS-1:0]  local_buffer_B1,
    output logic [DATA_BITS-1:0]  local_buffer_B2,
    output logic [DATA_BITS-1:0]  local_buffer_B3,
    input  logic                  sa_done,
    input  logic [DATAC_BITS-1:0] local_buffer_C0,
    input  logic [DATAC_BITS-1:0] local_buffer_C1,
    input  logic [DATAC_BITS-1:0] local_buffer_C2,
    input  logic [DATAC_BITS-1:0] local_buffer_C3
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ARM   = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    state_t                state_r, state_s;
    logic [2:0]            cnt_r, cnt_s, cnt_inc_s;
    logic [1:0]            cnt_dec_s;
    logic [ADDR_BITS-1:0]  a_base_r, a_base_s, b_base_r, b_base_s, c_base_r, c_base_s;
    logic [ADDR_BITS-1:0]  a_index_r, a_index_s, b_index_r, b_index_s, c_index_r, c_index_s;
    logic [DATA_BITS-1:0]  a_op_r [4];
    logic [DATA_BITS-1:0]  a_op_s [4];
    logic [DATA_BITS-1:0]  b_op_r [4];
    logic [DATA_BITS-1:0]  b_op_s [4];
    logic [DATAC_BITS-1:0] c_data_r, c_data_s;
    logic [DATAC_BITS-1:0] c_rows_s [4];
    logic                  busy_r, busy_s, done_r, done_s;
    logic                  c_wr_en_r, c_wr_en_s, sa_run_r, sa_run_s;

`ifdef SA_CTRL_TIMEOUT_EN
    localparam int RUN_CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
    logic [RUN_CNT_BITS-1:0] run_cnt_r, run_cnt_s;
    logic                    err_r, err_s;
`else
    // Only the watchdog build consumes the timeout limit.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    assign cnt_inc_s = cnt_r + 3'd1;
    // Operand slot written this LOAD cycle; cnt 4 maps to slot 3.
    assign cnt_dec_s = cnt_r[1:0] - 2'd1;

    assign c_rows_s[0] = local_buffer_C0;
    assign c_rows_s[1] = local_buffer_C1;
    assign c_rows_s[2] = local_buffer_C2;
    assign c_rows_s[3] = local_buffer_C3;

    // Next-state and next-output logic for the job sequencer.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        a_base_s  = a_base_r;
        b_base_s  = b_base_r;
        c_base_s  = c_base_r;
        a_index_s = a_index_r;
        b_index_s = b_index_r;
        c_index_s = c_index_r;
        a_op_s    = a_op_r;
        b_op_s    = b_op_r;
        c_data_s  = c_data_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        c_wr_en_s = 1'b0;
        sa_run_s  = 1'b0;
`ifdef SA_CTRL_TIMEOUT_EN
        run_cnt_s = run_cnt_r;
        err_s     = err_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    a_base_s  = a_base;
                    b_base_s  = b_base;
                    c_base_s  = c_base;
                    a_index_s = a_base;
                    b_index_s = b_base;
                    cnt_s     = 3'd0;
                    busy_s    = 1'b1;
`ifdef SA_CTRL_TIMEOUT_EN
                    err_s     = 1'b0;
`endif
                    state_s   = ST_LOAD;
                end else begin
                    busy_s = 1'b0;
                end
            end
            ST_LOAD: begin
                // Read data lags the index by one cycle, so the word for
                // index cnt-1 is on the data inputs now.
                if (cnt_r != 3'd0) begin
                    a_op_s[cnt_dec_s] = a_data_in;
                    b_op_s[cnt_dec_s] = b_data_in;
                end else begin
                    a_op_s = a_op_r;
                    b_op_s = b_op_r;
                end
                // Index is registered: present base+cnt+1 for the next cycle.
                if (cnt_r < 3'd3) begin
                    a_index_s = a_base_r + ADDR_BITS'(cnt_inc_s);
                    b_index_s = b_base_r + ADDR_BITS'(cnt_inc_s);
                end else begin
                    a_index_s = a_index_r;
                    b_index_s = b_index_r;
                end
                if (cnt_r == 3'd4) begin
                    cnt_s   = 3'd0;
                    state_s = ST_ARM;
                end else begin
                    cnt_s = cnt_inc_s;
                end
            end
            ST_ARM: begin
                sa_run_s = 1'b1;
`ifdef SA_CTRL_TIMEOUT_EN
                run_cnt_s = '0;
`endif
                state_s = ST_RUN;
            end
            ST_RUN: begin
                if (sa_done) begin
                    // Dropping sa_run here stops the array before it recomputes,
                    // so its C rows stay stable throughout DRAIN.
                    c_wr_en_s = 1'b1;
                    c_index_s = c_base_r;
                    c_data_s  = c_rows_s[0];
                    cnt_s     = 3'd0;
                    state_s   = ST_DRAIN;
                end else begin
`ifdef SA_CTRL_TIMEOUT_EN
                    if (run_cnt_r == RUN_CNT_BITS'(TIMEOUT_CYCLES - 1)) begin
                        err_s   = 1'b1;
                        done_s  = 1'b1;
                        state_s = ST_FIN;
                    end else begin
                        run_cnt_s = run_cnt_r + RUN_CNT_BITS'(1'b1);
                        sa_run_s  = 1'b1;
                    end
`else
                    sa_run_s = 1'b1;
`endif
                end
            end
            ST_DRAIN: begin
                if (cnt_r == 3'd3) begin
                    done_s  = 1'b1;
                    cnt_s   = 3'd0;
                    state_s = ST_FIN;
                end else begin
                    cnt_s     = cnt_inc_s;
                    c_wr_en_s = 1'b1;
                    c_index_s = c_base_r + ADDR_BITS'(cnt_inc_s);
                    c_data_s  = c_rows_s[cnt_inc_s[1:0]];
                end
            end
            ST_FIN: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 3'd0;
            a_base_r  <= '0;
            b_base_r  <= '0;
            c_base_r  <= '0;
            a_index_r <= '0;
            b_index_r <= '0;
            c_index_r <= '0;
            a_op_r    <= '{default: '0};
            b_op_r    <= '{default: '0};
            c_data_r  <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            c_wr_en_r <= 1'b0;
            sa_run_r  <= 1'b0;
`ifdef SA_CTRL_TIMEOUT_EN
            run_cnt_r <= '0;
            err_r     <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            a_base_r  <= a_base_s;
            b_base_r  <= b_base_s;
            c_base_r  <= c_base_s;
            a_index_r <= a_index_s;
            b_index_r <= b_index_s;
            c_index_r <= c_index_s;
            a_op_r    <= a_op_s;
            b_op_r    <= b_op_s;
            c_data_r  <= c_data_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            c_wr_en_r <= c_wr_en_s;
            sa_run_r  <= sa_run_s;
`ifdef SA_CTRL_TIMEOUT_EN
            run_cnt_r <= run_cnt_s;
            err_r     <= err_s;
`endif
        end
    end

    assign busy            = busy_r;
    assign done            = done_r;
    assign a_index         = a_index_r;
    assign b_index         = b_index_r;
    assign c_index         = c_index_r;
    assign c_wr_en         = c_wr_en_r;
    assign c_data_out      = c_data_r;
    assign sa_rst_n        = sa_run_r;
    assign local_buffer_A0 = a_op_r[0];
    assign local_buffer_A1 = a_op_r[1];
    assign local_buffer_A2 = a_op_r[2];
    assign local_buffer_A3 = a_op_r[3];
    assign local_buffer_B0 = b_op_r[0];
    assign local_buffer_B1 = b_op_r[1];
    assign local_buffer_B2 = b_op_r[2];
    assign local_buffer_B3 = b_op_r[3];
`ifdef SA_CTRL_TIMEOUT_EN
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sa_ctrl.sv
// tb_sa_ctrl - bench for sa_ctrl with behavioural A/B RAMs, a C write monitor
// and a simple array model whose sa_done latency is set per job.
// Job timing is measured in posedges k after E0 (the edge accepting start);
// outputs are sampled on the negedge following edge E_k.
module tb_sa_ctrl;

    logic         clk = 1'b0;
    logic         rst_n, start, busy, done, err, c_wr_en, sa_rst_n, sa_done;
    logic [15:0]  a_base, b_base, c_base, a_index, b_index, c_index;
    logic [31:0]  a_data_in, b_data_in;
    logic [127:0] c_data_out;
    logic [31:0]  la0, la1, la2, la3, lb0, lb1, lb2, lb3;
    logic [127:0] sa_c [4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0]        a_base, b_base, c_base;
        logic [3:0][31:0]   a_w, b_w;
        logic [3:0][127:0]  c_row;
        int                 lat;
        int                 done_k;
    } vec_t;
    vec_t vecs [4];

    typedef struct {
        logic [15:0]  idx;
        logic [127:0] data;
    } wr_t;
    wr_t wq [$];

    logic [31:0] ram_a [65536];
    logic [31:0] ram_b [65536];
    int          sa_lat = 0;
    int          sa_cnt = 0;

    sa_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_base(a_base), .b_base(b_base), .c_base(c_base),
        .busy(busy), .done(done), .err(err),
        .a_index(a_index), .b_index(b_index),
        .a_data_in(a_data_in), .b_data_in(b_data_in),
        .c_index(c_index), .c_wr_en(c_wr_en), .c_data_out(c_data_out),
        .sa_rst_n(sa_rst_n),
        .local_buffer_A0(la0), .local_buffer_A1(la1), .local_buffer_A2(la2), .local_buffer_A3(la3),
        .local_buffer_B0(lb0), .local_buffer_B1(lb1), .local_buffer_B2(lb2), .local_buffer_B3(lb3),
        .sa_done(sa_done),
        .local_buffer_C0(sa_c[0]), .local_buffer_C1(sa_c[1]),
        .local_buffer_C2(sa_c[2]), .local_buffer_C3(sa_c[3])
    );

    always #5 clk = ~clk;

    // A word k is column k of A (byte 3 = row 0); B word k is row k of B (byte 3 = col 0).
    function automatic logic [127:0] sa_row(input int r, input logic [3:0][31:0] aw,
                                            input logic [3:0][31:0] bw);
        logic [127:0] res;
        int           sum;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            sum = 0;
            for (int k = 0; k < 4; k++)
                sum += int'(aw[k][8*(3-r) +: 8]) * int'(bw[k][8*(3-c) +: 8]);
            res[32*(3-c) +: 32] = 32'(sum);
        end
        return res;
    endfunction

    function automatic logic [127:0] row(input int x0, input int x1, input int x2, input int x3);
        return {32'(x0), 32'(x1), 32'(x2), 32'(x3)};
    endfunction

    // Synchronous read RAMs, one cycle latency.
    always @(posedge clk) begin
        a_data_in <= ram_a[a_index];
        b_data_in <= ram_b[b_index];
    end

    // Array model: sa_done pulses after sa_lat enabled edges (0 = never).
    always @(posedge clk) begin
        if (sa_rst_n !== 1'b1) begin
            sa_cnt  <= 0;
            sa_done <= 1'b0;
        end else begin
            sa_cnt <= sa_cnt + 1;
            if (sa_lat != 0 && sa_cnt == sa_lat - 1) begin
                sa_done <= 1'b1;
                for (int r = 0; r < 4; r++)
                    sa_c[r] <= sa_row(r, {la3, la2, la1, la0}, {lb3, lb2, lb1, lb0});
            end else begin
                sa_done <= 1'b0;
            end
        end
    end

    // C buffer write monitor.
    always @(negedge clk) begin
        if (c_wr_en === 1'b1) wq.push_back('{c_index, c_data_out});
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_vec(input int v);
        logic [15:0] ad;
        for (int i = 0; i < 4; i++) begin
            ad = vecs[v].a_base + 16'(i);
            ram_a[ad] = vecs[v].a_w[i];
            ad = vecs[v].b_base + 16'(i);
            ram_b[ad] = vecs[v].b_w[i];
        end
        sa_lat = vecs[v].lat;
    endtask

    task automatic issue_start(input int v);
        @(negedge clk);
        a_base = vecs[v].a_base;
        b_base = vecs[v].b_base;
        c_base = vecs[v].c_base;
        start  = 1'b1;
        @(posedge clk);
    endtask

    task automatic chk_writes(input int v, input int first);
        logic [15:0] e;
        for (int i = 0; i < 4; i++) begin
            if (first + i < wq.size()) begin
                e = vecs[v].c_base + 16'(i);
                chk("wr_index", wq[first+i].idx, e);
                chk("wr_data", wq[first+i].data, vecs[v].c_row[i]);
            end
        end
    endtask

    // One job; poke_k >= 0 pulses start with other bases in cycle poke_k.
    task automatic run_job(input int v, input int poke_k);
        int          dk;
        int          lat;
        logic [15:0] e;
        wq.delete();
        load_vec(v);
        lat = vecs[v].lat;
        issue_start(v);
        dk = -1;
        for (int k = 0; k < 200 && dk < 0; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == poke_k) begin
                start = 1'b1; a_base = 16'h5555; b_base = 16'h6666; c_base = 16'h7777;
            end else if (k == poke_k + 1) begin
                start = 1'b0;
            end
            if (k < 4) begin
                e = vecs[v].a_base + 16'(k);
                chk("a_index", a_index, e);
                e = vecs[v].b_base + 16'(k);
                chk("b_index", b_index, e);
            end
            chk("sa_rst_n", sa_rst_n, (k >= 6 && k <= 6 + lat) ? 1'b1 : 1'b0);
            chk("c_wr_en", c_wr_en, (k >= 7 + lat && k <= 10 + lat) ? 1'b1 : 1'b0);
            chk("busy", busy, 1'b1);
            if (done === 1'b1) begin
                dk = k;
                chk("err", err, 1'b0);
            end
        end
        chk("done_latency", dk, vecs[v].done_k);
        @(negedge clk);
        chk("busy_after", busy, 1'b0);
        chk("done_pulse", done, 1'b0);
        chk("wr_count", wq.size(), 4);
        chk_writes(v, 0);
    endtask

    initial begin
        int dcount, d0, d1;
        rst_n = 1'b0; start = 1'b0;
        a_base = 16'h0000; b_base = 16'h0000; c_base = 16'h0000;

        // Words and rows are listed highest index first (word 3 / row 3 leftmost).
        vecs[0].a_base = 16'h0010; vecs[0].b_base = 16'h0020; vecs[0].c_base = 16'h0100;
        vecs[0].a_w = {32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000};
        vecs[0].b_w = {32'h0D0E0F10, 32'h090A0B0C, 32'h05060708, 32'h01020304};
        vecs[0].c_row = {row(13,14,15,16), row(9,10,11,12), row(5,6,7,8), row(1,2,3,4)};
        vecs[0].lat = 12; vecs[0].done_k = 23;
        // anti-diagonal A reverses the rows of B; A and C indices wrap
        vecs[1].a_base = 16'hFFFE; vecs[1].b_base = 16'h0040; vecs[1].c_base = 16'hFFFF;
        vecs[1].a_w = {32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001};
        vecs[1].b_w = vecs[0].b_w;
        vecs[1].c_row = {row(1,2,3,4), row(5,6,7,8), row(9,10,11,12), row(13,14,15,16)};
        vecs[1].lat = 12; vecs[1].done_k = 23;
        // A = 2I with a longer RUN phase
        vecs[2].a_base = 16'h0200; vecs[2].b_base = 16'h0300; vecs[2].c_base = 16'h0400;
        vecs[2].a_w = {32'h00000002, 32'h00000200, 32'h00020000, 32'h02000000};
        vecs[2].b_w = vecs[0].b_w;
        vecs[2].c_row = {row(26,28,30,32), row(18,20,22,24), row(10,12,14,16), row(2,4,6,8)};
        vecs[2].lat = 20; vecs[2].done_k = 31;
        // all-ones A gives column sums of B; B index wraps; shortest RUN
        vecs[3].a_base = 16'h1234; vecs[3].b_base = 16'hFFFD; vecs[3].c_base = 16'h2000;
        vecs[3].a_w = {4{32'h01010101}};
        vecs[3].b_w = vecs[0].b_w;
        vecs[3].c_row = {4{row(28,32,36,40)}};
        vecs[3].lat = 1; vecs[3].done_k = 12;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_c_wr_en", c_wr_en, 1'b0);
        chk("rst_sa_rst_n", sa_rst_n, 1'b0);
        chk("rst_a_index", a_index, 16'h0000);
        chk("rst_op_a0", la0, 32'h0);
        chk("rst_op_b3", lb3, 32'h0);
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++) run_job(v, -1);

        // start pulsed during RUN with other bases must be ignored
        run_job(0, 10);

        // reset mid-RUN: outputs drop at once, nothing is written
        wq.delete();
        load_vec(0);
        issue_start(0);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_rst_sa_rst_n", sa_rst_n, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sa_rst_n", sa_rst_n, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_c_wr_en", c_wr_en, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        chk("mid_rst_done_cnt", dcount, 0);
        chk("mid_rst_wr_cnt", wq.size(), 0);
        run_job(1, -1);

        // start held high: second job is accepted in the IDLE cycle after FIN
        wq.delete();
        load_vec(0);
        issue_start(0);
        d0 = -1; d1 = -1;
        for (int k = 0; k < 120 && d1 < 0; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (d0 < 0) d0 = k;
                else d1 = k;
            end
            if (k == 24) chk("b2b_idle_busy", busy, 1'b0);
        end
        start = 1'b0;
        chk("b2b_first_done", d0, 23);
        chk("b2b_second_done", d1, 48);
        chk("b2b_wr_count", wq.size(), 8);
        chk_writes(0, 0);
        chk_writes(0, 4);
        @(negedge clk);

`ifdef SA_CTRL_TIMEOUT_EN
        // array never finishes: watchdog ends the job after 64 RUN cycles
        wq.delete();
        load_vec(0);
        sa_lat = 0;
        issue_start(0);
        d0 = -1;
        for (int k = 0; k < 150 && d0 < 0; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (done === 1'b1) begin
                d0 = k;
                chk("to_err", err, 1'b1);
                chk("to_sa_rst_n", sa_rst_n, 1'b0);
            end
        end
        chk("to_done_latency", d0, 70);
        chk("to_wr_count", wq.size(), 0);
        @(negedge clk);
        chk("to_sa_rst_n_after", sa_rst_n, 1'b0);
        chk("to_busy_after", busy, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
